// File: rtl/eb_wb_ram_slave.sv
// -----------------------------------------------------------------------------
// eb_wb_ram_slave
// Pipelined Wishbone B4 word-addressed RAM slave. It is the target memory
// placed directly behind the Etherbone core's master port.
//
// Features
//   - programmable ack latency (g_latency = 1..4 cycles after acceptance)
//   - deterministic back-pressure: after g_burst_max accepted requests,
//     stall is raised for exactly one cycle (g_burst_max = 0 disables it)
//   - byte-lane write enables via slave_sel_i
//   - optional out-of-range error response, enabled by defining the macro
//     EB_RAM_RANGE_ERR_EN. When the macro is undefined, err is always 0 and
//     address bits above g_addr_bits alias into the RAM.
//
// Parameters
//   g_addr_bits  word address width (< 32); depth = 2**g_addr_bits words
//   g_latency    cycles from acceptance to ack/err (1..4)
//   g_burst_max  accepted requests per burst before a 1-cycle stall
//
// Ports
//   clk_i          system clock
//   nRst_i         asynchronous active-low reset
//   slave_cyc_i    WB cycle
//   slave_stb_i    WB strobe
//   slave_we_i     write enable
//   slave_sel_i    byte lane select, bit n covers dat[8n+7:8n]
//   slave_adr_i    word address
//   slave_dat_i    write data
//   slave_dat_o    read data, valid with ack (0 for write acks)
//   slave_ack_o    transfer acknowledge (1-cycle pulse per request)
//   slave_err_o    transfer error (1-cycle pulse per out-of-range request)
//   slave_stall_o  pipeline stall
// -----------------------------------------------------------------------------
module eb_wb_ram_slave #(
    parameter int g_addr_bits = 10,
    parameter int g_latency   = 1,
    parameter int g_burst_max = 0
) (
    input  logic        clk_i,
    input  logic        nRst_i,
    input  logic        slave_cyc_i,
    input  logic        slave_stb_i,
    input  logic        slave_we_i,
    input  logic [3:0]  slave_sel_i,
    input  logic [31:0] slave_adr_i,
    input  logic [31:0] slave_dat_i,
    output logic [31:0] slave_dat_o,
    output logic        slave_ack_o,
    output logic        slave_err_o,
    output logic        slave_stall_o
);

    localparam int c_depth = 2 ** g_addr_bits;
    localparam int c_cnt_w = (g_burst_max > 0) ? $clog2(g_burst_max + 1) : 1;

    logic [31:0]            r_mem [0:c_depth-1];
    logic [g_latency-1:0]   r_ack_pipe;
    logic [g_latency-1:0]   r_err_pipe;
    logic [31:0]            r_dat_pipe [0:g_latency-1];
    logic [c_cnt_w-1:0]     r_burst_cnt;
    logic                   r_stall;

    logic                   w_accept;
    logic                   w_oor;
    logic                   w_wr_en;
    logic                   w_burst_end;
    logic [g_addr_bits-1:0] w_addr;

    assign w_addr   = slave_adr_i[g_addr_bits-1:0];
    assign w_accept = slave_cyc_i & slave_stb_i & ~r_stall;
    assign w_wr_en  = w_accept & slave_we_i & ~w_oor;

`ifdef EB_RAM_RANGE_ERR_EN
    assign w_oor = |slave_adr_i[31:g_addr_bits];
`else
    // Upper address bits alias into the RAM; they are deliberately unused.
    logic w_unused_adr;
    assign w_unused_adr = ^slave_adr_i[31:g_addr_bits];
    assign w_oor        = 1'b0;
`endif

    // Outputs come straight from the last pipeline stage. Stall is gated by
    // cyc so it can never be seen high while the master has dropped the cycle.
    assign slave_ack_o   = r_ack_pipe[g_latency-1];
    assign slave_err_o   = r_err_pipe[g_latency-1];
    assign slave_dat_o   = r_dat_pipe[g_latency-1];
    assign slave_stall_o = r_stall & slave_cyc_i;

    // Detect the acceptance that completes a burst.
    always_comb begin
        w_burst_end = 1'b0;
        if (g_burst_max > 0) begin
            w_burst_end = (r_burst_cnt == c_cnt_w'(g_burst_max - 1));
        end else begin
            w_burst_end = 1'b0;
        end
    end

    // Burst counter and the one-cycle forced stall that follows a full burst.
    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            r_burst_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (!slave_cyc_i) begin
            r_burst_cnt <= '0;
            r_stall     <= 1'b0;
        end else if (w_accept) begin
            if (w_burst_end) begin
                r_burst_cnt <= '0;
                r_stall     <= 1'b1;
            end else if (g_burst_max > 0) begin
                r_burst_cnt <= r_burst_cnt + c_cnt_w'(1);
                r_stall     <= 1'b0;
            end else begin
                r_burst_cnt <= '0;
                r_stall     <= 1'b0;
            end
        end else begin
            r_stall     <= 1'b0;
        end
    end

    // RAM write port with byte-lane enables; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (slave_sel_i[b]) begin
                    r_mem[w_addr][8*b +: 8] <= slave_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the accepted request (read data is
    // sampled on the acceptance edge), later stages shift it toward the output.
    // Dropping cyc flushes every stage so aborted requests never respond.
    always_ff @(posedge clk_i or negedge nRst_i) begin
        if (!nRst_i) begin
            r_ack_pipe <= '0;
            r_err_pipe <= '0;
            for (int i = 0; i < g_latency; i++) begin
                r_dat_pipe[i] <= 32'h0000_0000;
            end
        end else if (!slave_cyc_i) begin
            r_ack_pipe <= '0;
            r_err_pipe <= '0;
            for (int i = 0; i < g_latency; i++) begin
                r_dat_pipe[i] <= 32'h0000_0000;
            end
        end else begin
            r_ack_pipe[0] <= w_accept & ~w_oor;
            r_err_pipe[0] <= w_accept & w_oor;
            if (w_accept && !slave_we_i && !w_oor) begin
                r_dat_pipe[0] <= r_mem[w_addr];
            end else begin
                r_dat_pipe[0] <= 32'h0000_0000;
            end
            for (int i = 1; i < g_latency; i++) begin
                r_ack_pipe[i] <= r_ack_pipe[i-1];
                r_err_pipe[i] <= r_err_pipe[i-1];
                r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_eb_wb_ram_slave.sv
// -----------------------------------------------------------------------------
// Testbench for eb_wb_ram_slave. Three instances cover the configurations:
//   u0: latency 1, no back-pressure
//   u1: latency 3, no back-pressure
//   u2: latency 4, burst of 4 then forced stall
// Expected responses are pushed to a scoreboard queue at acceptance (using a
// bench-side memory model) and popped as acks/errs appear.
// -----------------------------------------------------------------------------
module tb_eb_wb_ram_slave;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } op_t;

    typedef struct {
        bit          is_err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [3:0]  sel   [3];
    logic [31:0] adr   [3];
    logic [31:0] wdat  [3];
    logic [31:0] rdat  [3];
    logic        ack   [3];
    logic        err   [3];
    logic        stall [3];

    int          n_checks;
    int          n_err;
    int          cyc_n;
    logic [31:0] mdl [3][1024];
    op_t         ops_q [$];
    exp_t        exp_q [$];

    eb_wb_ram_slave #(.g_addr_bits(10), .g_latency(1), .g_burst_max(0)) u0 (
        .clk_i(clk), .nRst_i(rst_n),
        .slave_cyc_i(cyc[0]), .slave_stb_i(stb[0]), .slave_we_i(we[0]),
        .slave_sel_i(sel[0]), .slave_adr_i(adr[0]), .slave_dat_i(wdat[0]),
        .slave_dat_o(rdat[0]), .slave_ack_o(ack[0]), .slave_err_o(err[0]),
        .slave_stall_o(stall[0])
    );

    eb_wb_ram_slave #(.g_addr_bits(10), .g_latency(3), .g_burst_max(0)) u1 (
        .clk_i(clk), .nRst_i(rst_n),
        .slave_cyc_i(cyc[1]), .slave_stb_i(stb[1]), .slave_we_i(we[1]),
        .slave_sel_i(sel[1]), .slave_adr_i(adr[1]), .slave_dat_i(wdat[1]),
        .slave_dat_o(rdat[1]), .slave_ack_o(ack[1]), .slave_err_o(err[1]),
        .slave_stall_o(stall[1])
    );

    eb_wb_ram_slave #(.g_addr_bits(10), .g_latency(4), .g_burst_max(4)) u2 (
        .clk_i(clk), .nRst_i(rst_n),
        .slave_cyc_i(cyc[2]), .slave_stb_i(stb[2]), .slave_we_i(we[2]),
        .slave_sel_i(sel[2]), .slave_adr_i(adr[2]), .slave_dat_i(wdat[2]),
        .slave_dat_o(rdat[2]), .slave_ack_o(ack[2]), .slave_err_o(err[2]),
        .slave_stall_o(stall[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    task automatic push_op(input logic w, input logic [3:0] s, input logic [31:0] a, input logic [31:0] d);
        op_t op;
        op.we = w; op.sel = s; op.adr = a; op.dat = d;
        ops_q.push_back(op);
    endtask

    // Streams every queued op with stb held high, honouring stall, and checks
    // responses, latency and the stall pattern each cycle. Entered and left at
    // a falling edge; drops cyc at the end.
    task automatic run_ops(input int k, input int lat, input int burst, input string name);
        int   idx;
        int   guard;
        int   acc_n;
        bit   acc_last;
        bit   exp_stall;
        op_t  op;
        exp_t e;
        idx = 0; guard = 0; acc_n = 0; acc_last = 1'b0;
        while ((idx < ops_q.size() || exp_q.size() != 0) && guard < 300) begin
            if (idx < ops_q.size()) begin
                op = ops_q[idx];
                cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = op.we;
                sel[k] = op.sel; adr[k] = op.adr; wdat[k] = op.dat;
            end else begin
                stb[k] = 1'b0;
            end
            #1;
            acc_last = stb[k] && !stall[k];
            if (acc_last) begin
                e.is_err = 1'b0;
`ifdef EB_RAM_RANGE_ERR_EN
                e.is_err = (op.adr[31:10] != 22'h0);
`endif
                e.cyc = cyc_n + lat;
                e.dat = 32'h0;
                if (!e.is_err) begin
                    if (op.we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (op.sel[b]) mdl[k][op.adr[9:0]][8*b +: 8] = op.dat[8*b +: 8];
                        end
                    end else begin
                        e.dat = mdl[k][op.adr[9:0]];
                    end
                end
                exp_q.push_back(e);
                idx++;
                acc_n++;
            end
            @(posedge clk); @(negedge clk);
            if (ack[k] === 1'b1 || err[k] === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s unexpected: ack=%0b err=%0b dat=%08h at cycle %0d, required no response",
                             name, ack[k], err[k], rdat[k], cyc_n);
                end else begin
                    e = exp_q.pop_front();
                    if ({ack[k], err[k]} !== {~e.is_err, e.is_err} || rdat[k] !== e.dat || cyc_n != e.cyc) begin
                        n_err++;
                        $display("FAIL %s resp: ack=%0b err=%0b dat=%08h cycle=%0d, required ack=%0b err=%0b dat=%08h cycle=%0d",
                                 name, ack[k], err[k], rdat[k], cyc_n, ~e.is_err, e.is_err, e.dat, e.cyc);
                    end
                end
            end
            exp_stall = (burst > 0) && acc_last && ((acc_n % burst) == 0);
            n_checks++;
            if (stall[k] !== exp_stall) begin
                n_err++;
                $display("FAIL %s stall: got %0b after %0d accepts, required %0b", name, stall[k], acc_n, exp_stall);
            end
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0 || idx < ops_q.size()) begin
            n_err++;
            $display("FAIL %s timeout: %0d responses and %0d ops outstanding, required 0",
                     name, exp_q.size(), ops_q.size() - idx);
        end
        exp_q.delete();
        ops_q.delete();
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        @(posedge clk); @(negedge clk);
        n_checks++;
        if (ack[k] !== 1'b0 || err[k] !== 1'b0 || stall[k] !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: ack=%0b err=%0b stall=%0b, required all 0", name, ack[k], err[k], stall[k]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (ack[k] !== 1'b0 || err[k] !== 1'b0 || stall[k] !== 1'b0 || rdat[k] !== 32'h0) begin
                n_err++;
                $display("FAIL reset u%0d: ack=%0b err=%0b stall=%0b dat=%08h, required all 0",
                         k, ack[k], err[k], stall[k], rdat[k]);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_write_read;
        push_op(1'b1, 4'hF, 32'h5, 32'hDEADBEEF);
        push_op(1'b0, 4'hF, 32'h5, 32'h0);
        run_ops(0, 1, 0, "write_read");
    endtask

    task automatic test_byte_lanes;
        push_op(1'b1, 4'hF, 32'h7, 32'h11223344);
        push_op(1'b1, 4'h5, 32'h7, 32'hAABBCCDD);
        push_op(1'b0, 4'h0, 32'h7, 32'h0);
        run_ops(0, 1, 0, "byte_lanes");
    endtask

    task automatic test_stb_no_cyc;
        cyc[0] = 1'b0; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
        adr[0] = 32'h5; wdat[0] = 32'h0BAD0BAD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (ack[0] !== 1'b0 || err[0] !== 1'b0 || stall[0] !== 1'b0) begin
                n_err++;
                $display("FAIL stb_no_cyc: ack=%0b err=%0b stall=%0b, required all 0", ack[0], err[0], stall[0]);
            end
        end
        stb[0] = 1'b0; we[0] = 1'b0;
        push_op(1'b0, 4'hF, 32'h5, 32'h0);
        run_ops(0, 1, 0, "stb_no_cyc_read");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) push_op(1'b1, 4'hF, i, i * 32'h01010101);
        run_ops(1, 3, 0, "b2b_preload");
        for (int i = 0; i < 8; i++) push_op(1'b0, 4'hF, i, 32'h0);
        run_ops(1, 3, 0, "b2b_read");
    endtask

    task automatic test_burst_stall;
        for (int i = 0; i < 10; i++) push_op(1'b1, 4'hF, i, 32'hA500_0000 + i * 32'h111);
        run_ops(2, 4, 4, "burst_write");
        for (int i = 0; i < 10; i++) push_op(1'b0, 4'hF, i, 32'h0);
        run_ops(2, 4, 4, "burst_read");
    endtask

    task automatic test_abort;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 4'hF; adr[2] = 32'h1;
        @(posedge clk); @(negedge clk);
        adr[2] = 32'h2;
        @(posedge clk); @(negedge clk);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (ack[2] !== 1'b0 || err[2] !== 1'b0) begin
                n_err++;
                $display("FAIL abort: ack=%0b err=%0b %0d cycles after drop, required 0", ack[2], err[2], i);
            end
        end
        push_op(1'b0, 4'hF, 32'h1, 32'h0);
        run_ops(2, 4, 4, "abort_reread");
    endtask

    task automatic test_reset_midop;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h3;
        @(posedge clk); @(negedge clk);
        stb[1] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (ack[1] !== 1'b0 || err[1] !== 1'b0 || rdat[1] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_midop: ack=%0b err=%0b dat=%08h, required 0", ack[1], err[1], rdat[1]);
            end
        end
        cyc[1] = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_range;
        push_op(1'b1, 4'hF, 32'h0,   32'hCAFEF00D);
        push_op(1'b1, 4'hF, 32'h400, 32'h12345678);
        push_op(1'b0, 4'hF, 32'h0,   32'h0);
        run_ops(0, 1, 0, "range");
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
            sel[k] = 4'h0; adr[k] = 32'h0; wdat[k] = 32'h0;
        end
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_stb_no_cyc();
        test_back_to_back();
        test_burst_stall();
        test_abort();
        test_reset_midop();
        test_range();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
